// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, baud divisor and parity helpers.
// The parity function is also used by the command transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rxState_e;

  function automatic int baudDiv(input int clkFreq, input int baud);
    return clkFreq / baud;
  endfunction

  // Returns the bit that makes the total count of ones (data + parity) odd.
  function automatic logic oddParity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Single-frame UART receiver: synchronizer, bit-rate counter and frame FSM.
// Strobes are combinational and asserted in the stop-bit sample cycle.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int CHECK    = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byteVld_o,
  output logic       perr_o,
  output logic       ferr_o,
  output logic       idle_o,
  output logic       startEdge_o
);

  localparam int BAUD_DIV = baudDiv(CLK_FREQ, BAUD);
  localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] SAMPLE_PT = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] LAST_CNT  = BW'(BAUD_DIV - 1);

  logic          rxMeta_q, rxSync_q, rxPrev_q;
  rxState_e      state_q, state_d;
  logic [BW-1:0] brCnt_q, brCnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic          perr_q, perr_d;
  logic          sample, fallEdge;

  assign sample   = (brCnt_q == SAMPLE_PT);
  assign fallEdge = rxPrev_q & ~rxSync_q;
  assign byte_o   = shift_q;
  assign idle_o   = (state_q == IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
      state_q  <= IDLE;
      brCnt_q  <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      perr_q   <= 1'b0;
    end else begin
      rxMeta_q <= rx_i;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
      state_q  <= state_d;
      brCnt_q  <= brCnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      perr_q   <= perr_d;
    end
  end

  // The bit counter free-runs once a start edge clears it, so every later
  // sample point lands exactly one bit period after the previous one.
  always_comb begin
    state_d     = state_q;
    brCnt_d     = (brCnt_q == LAST_CNT) ? '0 : brCnt_q + 1'b1;
    bitIdx_d    = bitIdx_q;
    shift_d     = shift_q;
    perr_d      = perr_q;
    byteVld_o   = 1'b0;
    perr_o      = 1'b0;
    ferr_o      = 1'b0;
    startEdge_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        brCnt_d = '0;
        if (fallEdge) begin
          state_d     = START;
          startEdge_o = 1'b1;
          bitIdx_d    = '0;
          perr_d      = 1'b0;
        end
      end
      START: begin
        if (sample) state_d = rxSync_q ? IDLE : DATA;
      end
      DATA: begin
        if (sample) begin
          shift_d  = {rxSync_q, shift_q[7:1]};
          bitIdx_d = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) state_d = (CHECK != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (sample) begin
          if (rxSync_q != oddParity(shift_q)) perr_d = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          if (!rxSync_q) begin
            ferr_o  = 1'b1;
            state_d = BREAK;
          end else if (perr_q) begin
            perr_o  = 1'b1;
            state_d = IDLE;
          end else begin
            byteVld_o = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      BREAK: begin
        brCnt_d = '0;
        if (rxSync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: packs received bytes (first byte in the MSBs) into
// DATA_WIDTH-bit words, with an inter-byte timeout that drops partial words.
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int DATA_WIDTH   = 16,
  parameter int CHECK        = 1,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_vld,
  output logic                  parity_err,
  output logic                  frame_err
);

  localparam int BAUD_DIV = baudDiv(CLK_FREQ, BAUD);
  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int CW       = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int LIMIT    = TIMEOUT_BITS * BAUD_DIV;
  localparam int TW       = $clog2(LIMIT + 1);

  logic [7:0]            rxByte;
  logic                  byteStb, perrStb, ferrStb, rxIdle, startEdge;
  logic [DATA_WIDTH-1:0] wordSr_q, wordSr_d, dataOut_q, dataOut_d, nextWord;
  logic [CW-1:0]         byteCnt_q, byteCnt_d;
  logic [TW-1:0]         idleCnt_q, idleCnt_d;
  logic                  dataVld_q, dataVld_d;
  logic                  parityErr_q, parityErr_d;
  logic                  frameErr_q, frameErr_d;
  logic                  counting, expired;

  uart_rx_byte #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .CHECK   (CHECK)
  ) uRxByte (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_i       (rx),
    .byte_o     (rxByte),
    .byteVld_o  (byteStb),
    .perr_o     (perrStb),
    .ferr_o     (ferrStb),
    .idle_o     (rxIdle),
    .startEdge_o(startEdge)
  );

  assign data_out   = dataOut_q;
  assign data_vld   = dataVld_q;
  assign parity_err = parityErr_q;
  assign frame_err  = frameErr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wordSr_q    <= '0;
      dataOut_q   <= '0;
      byteCnt_q   <= '0;
      idleCnt_q   <= '0;
      dataVld_q   <= 1'b0;
      parityErr_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      wordSr_q    <= wordSr_d;
      dataOut_q   <= dataOut_d;
      byteCnt_q   <= byteCnt_d;
      idleCnt_q   <= idleCnt_d;
      dataVld_q   <= dataVld_d;
      parityErr_q <= parityErr_d;
      frameErr_q  <= frameErr_d;
    end
  end

  // A start edge suppresses the timeout in its cycle, so an edge that
  // coincides with expiry keeps the byte in the current word.
  always_comb begin
    nextWord    = (wordSr_q << 8) | DATA_WIDTH'(rxByte);
    counting    = (byteCnt_q != '0) && rxIdle && !startEdge;
    expired     = counting && (idleCnt_q == TW'(LIMIT));
    wordSr_d    = wordSr_q;
    dataOut_d   = dataOut_q;
    byteCnt_d   = byteCnt_q;
    idleCnt_d   = '0;
    dataVld_d   = 1'b0;
    parityErr_d = perrStb;
    frameErr_d  = ferrStb;
    if (counting && !expired) idleCnt_d = idleCnt_q + 1'b1;
    if (perrStb || ferrStb) begin
      byteCnt_d = '0;
    end else if (byteStb) begin
      wordSr_d = nextWord;
      if (byteCnt_q == CW'(BYTES - 1)) begin
        dataOut_d = nextWord;
        dataVld_d = 1'b1;
        byteCnt_d = '0;
      end else begin
        byteCnt_d = byteCnt_q + 1'b1;
      end
    end else if (expired) begin
      byteCnt_d = '0;
    end
  end

endmodule
